id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe_if.sv | 45 ++++
 rtl/id_ex_pipe.sv | 86 ++++++++
 tb/tb_id_ex_pipe.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_if.sv
// rtl/id_ex_pipe_if.sv - ID/EX pipeline register bundle: decode-side inputs, EX-stage copies, hazard status
interface id_ex_pipe_if #(
    parameter int n = 32
);
    logic          flush;
    logic          id_valid;
    logic [n-1:0]  id_pc;
    logic [n-1:0]  id_rd1;
    logic [n-1:0]  id_rd2;
    logic [n-1:0]  id_imm;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic [4:0]    id_rd;
    logic [7:0]    id_ctrl;

    logic          ex_valid;
    logic [n-1:0]  ex_pc;
    logic [n-1:0]  ex_rd1;
    logic [n-1:0]  ex_rd2;
    logic [n-1:0]  ex_imm;
    logic [4:0]    ex_rs1;
    logic [4:0]    ex_rs2;
    logic [4:0]    ex_rd;
    logic [7:0]    ex_ctrl;

    logic          stall;
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;

    modport master (
        output flush, id_valid, id_pc, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_rd, id_ctrl,
        input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl,
               stall, stall_cnt, flush_cnt
    );

    modport slave (
        input  flush, id_valid, id_pc, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_rd, id_ctrl,
        output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl,
               stall, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use stall, flush squash and saturating event counters
module id_ex_pipe #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_pipe_if.slave  bus
);
    localparam int CTRL_MEMREAD = 6;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic          ex_valid_q;
    logic [n-1:0]  ex_pc_q;
    logic [n-1:0]  ex_rd1_q;
    logic [n-1:0]  ex_rd2_q;
    logic [n-1:0]  ex_imm_q;
    logic [4:0]    ex_rs1_q;
    logic [4:0]    ex_rs2_q;
    logic [4:0]    ex_rd_q;
    logic [7:0]    ex_ctrl_q;
    logic [15:0]   stall_cnt_q;
    logic [15:0]   flush_cnt_q;

    logic          hazard;
    logic          stall;

    // x0 is never written, so a load targeting it cannot create a dependency
    always_comb begin
        hazard = ex_valid_q & ex_ctrl_q[CTRL_MEMREAD] & (ex_rd_q != 5'd0) & bus.id_valid &
                 ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));
        stall  = hazard & ~bus.flush;
    end

    // Flush and stall both squash only valid/ctrl; the data fields keep their old contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_ctrl_q  <= '0;
        end else if (bus.flush || stall) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= bus.id_valid;
            ex_pc_q    <= bus.id_pc;
            ex_rd1_q   <= bus.id_rd1;
            ex_rd2_q   <= bus.id_rd2;
            ex_imm_q   <= bus.id_imm;
            ex_rs1_q   <= bus.id_rs1;
            ex_rs2_q   <= bus.id_rs2;
            ex_rd_q    <= bus.id_rd;
            ex_ctrl_q  <= bus.id_valid ? bus.id_ctrl : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != CNT_MAX))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (bus.flush && (flush_cnt_q != CNT_MAX))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_pc     = ex_pc_q;
    assign bus.ex_rd1    = ex_rd1_q;
    assign bus.ex_rd2    = ex_rd2_q;
    assign bus.ex_imm    = ex_imm_q;
    assign bus.ex_rs1    = ex_rs1_q;
    assign bus.ex_rs2    = ex_rs2_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.ex_ctrl   = ex_ctrl_q;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - directed self-checking bench for id_ex_pipe
module tb_id_ex_pipe;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    id_ex_pipe_if #(.n(32)) bus ();

    id_ex_pipe #(.n(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [7:0] ctrl);
        bus.id_valid = v;
        bus.id_pc    = pc;
        bus.id_rd1   = rd1;
        bus.id_rd2   = rd1 ^ 32'hFFFF_0000;
        bus.id_imm   = pc + 32'd4;
        bus.id_rs1   = rs1;
        bus.id_rs2   = rs2;
        bus.id_rd    = rd;
        bus.id_ctrl  = ctrl;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.ex_valid), 64'd0);
        chk({tag, "_pc"},    64'(bus.ex_pc),    64'd0);
        chk({tag, "_rd1"},   64'(bus.ex_rd1),   64'd0);
        chk({tag, "_rd2"},   64'(bus.ex_rd2),   64'd0);
        chk({tag, "_imm"},   64'(bus.ex_imm),   64'd0);
        chk({tag, "_rs"},    64'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd}), 64'd0);
        chk({tag, "_ctrl"},  64'(bus.ex_ctrl),  64'd0);
        chk({tag, "_scnt"},  64'(bus.stall_cnt), 64'd0);
        chk({tag, "_fcnt"},  64'(bus.flush_cnt), 64'd0);
        chk({tag, "_stall"}, 64'(bus.stall),    64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.flush = 1'b0;
        drive_id(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00);

        // reset state before any clock edge
        #2;
        chk_all_zero("reset");

        // release reset away from the clock edge
        tick();
        #3 rst = 1'b0;
        tick();

        // normal flow
        drive_id(1'b1, 32'h10, 32'hA5, 5'd1, 5'd2, 5'd3, 8'h82);
        #1 chk("norm_stall_pre", 64'(bus.stall), 64'd0);
        tick();
        chk("norm_pc",    64'(bus.ex_pc),   64'h10);
        chk("norm_rd1",   64'(bus.ex_rd1),  64'hA5);
        chk("norm_rd2",   64'(bus.ex_rd2),  64'hFFFF_00A5);
        chk("norm_imm",   64'(bus.ex_imm),  64'h14);
        chk("norm_rd",    64'(bus.ex_rd),   64'd3);
        chk("norm_ctrl",  64'(bus.ex_ctrl), 64'h82);
        chk("norm_valid", 64'(bus.ex_valid), 64'd1);
        chk("norm_stall", 64'(bus.stall),   64'd0);

        // load-use: lw x5 into EX, dependent instruction in ID
        drive_id(1'b1, 32'h20, 32'h0, 5'd1, 5'd0, 5'd5, 8'hD0);
        tick();
        drive_id(1'b1, 32'h24, 32'h11, 5'd1, 5'd5, 5'd6, 8'h82);
        #1 chk("lu_stall", 64'(bus.stall), 64'd1);
        tick();
        chk("lu_bub_valid", 64'(bus.ex_valid), 64'd0);
        chk("lu_bub_ctrl",  64'(bus.ex_ctrl),  64'd0);
        chk("lu_bub_pc",    64'(bus.ex_pc),    64'h20);
        chk("lu_scnt",      64'(bus.stall_cnt), 64'd1);
        chk("lu_stall_off", 64'(bus.stall),    64'd0);
        tick();
        chk("lu_load_pc",    64'(bus.ex_pc),    64'h24);
        chk("lu_load_valid", 64'(bus.ex_valid), 64'd1);
        chk("lu_load_ctrl",  64'(bus.ex_ctrl),  64'h82);
        chk("lu_scnt_hold",  64'(bus.stall_cnt), 64'd1);

        // load to x0 never stalls
        drive_id(1'b1, 32'h30, 32'h0, 5'd2, 5'd0, 5'd0, 8'hD0);
        tick();
        drive_id(1'b1, 32'h34, 32'h22, 5'd0, 5'd0, 5'd8, 8'h82);
        #1 chk("x0_stall", 64'(bus.stall), 64'd0);
        tick();
        chk("x0_pc",    64'(bus.ex_pc),    64'h34);
        chk("x0_valid", 64'(bus.ex_valid), 64'd1);

        // flush together with hazard
        drive_id(1'b1, 32'h40, 32'h0, 5'd1, 5'd2, 5'd7, 8'hD0);
        tick();
        drive_id(1'b1, 32'h44, 32'h33, 5'd7, 5'd1, 5'd9, 8'h82);
        bus.flush = 1'b1;
        #1 chk("fh_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.flush = 1'b0;
        chk("fh_valid", 64'(bus.ex_valid), 64'd0);
        chk("fh_ctrl",  64'(bus.ex_ctrl),  64'd0);
        chk("fh_pc",    64'(bus.ex_pc),    64'h40);
        chk("fh_fcnt",  64'(bus.flush_cnt), 64'd1);
        chk("fh_scnt",  64'(bus.stall_cnt), 64'd1);

        // invalid ID slot loads fields but zero control
        drive_id(1'b0, 32'h50, 32'h44, 5'd3, 5'd4, 5'd5, 8'h82);
        tick();
        chk("inv_valid", 64'(bus.ex_valid), 64'd0);
        chk("inv_ctrl",  64'(bus.ex_ctrl),  64'd0);
        chk("inv_pc",    64'(bus.ex_pc),    64'h50);

        // stall counter saturation, preloaded one below the limit
        force dut.stall_cnt_q = 16'hFFFE;
        #1 release dut.stall_cnt_q;
        for (int k = 0; k < 2; k++) begin
            drive_id(1'b1, 32'h60, 32'h0, 5'd1, 5'd2, 5'd9, 8'hD0);
            tick();
            drive_id(1'b1, 32'h64, 32'h55, 5'd9, 5'd9, 5'd10, 8'h82);
            #1 chk("sat_stall", 64'(bus.stall), 64'd1);
            tick();
            chk("sat_scnt", 64'(bus.stall_cnt), 64'hFFFF);
        end

        // flush counter saturation with back-to-back flushes
        force dut.flush_cnt_q = 16'hFFFD;
        #1 release dut.flush_cnt_q;
        bus.flush = 1'b1;
        tick();
        chk("fsat_1", 64'(bus.flush_cnt), 64'hFFFE);
        tick();
        chk("fsat_2", 64'(bus.flush_cnt), 64'hFFFF);
        tick();
        chk("fsat_3", 64'(bus.flush_cnt), 64'hFFFF);
        bus.flush = 1'b0;

        // async reset during a stall
        drive_id(1'b1, 32'h70, 32'h0, 5'd1, 5'd2, 5'd11, 8'hD0);
        tick();
        drive_id(1'b1, 32'h74, 32'h66, 5'd11, 5'd0, 5'd12, 8'h82);
        #1 chk("ar_stall_pre", 64'(bus.stall), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        #2 rst = 1'b0;
        tick();
        chk("ar_load_pc",    64'(bus.ex_pc),    64'h74);
        chk("ar_load_valid", 64'(bus.ex_valid), 64'd1);
        chk("ar_load_ctrl",  64'(bus.ex_ctrl),  64'h82);
        chk("ar_scnt",       64'(bus.stall_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
